// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package riscv_mc_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      JAL      = 4'd8,
      ALUWB    = 4'd9,
      BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation select from the FSM's ALUOp and the instruction funct fields.
module alu_decoder
   import riscv_mc_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 alone would turn addi with a negative immediate into sub
               3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core with shared ALU and memory.
//   state    | meaning
//   FETCH    | read instr at PC into IR, PC <= PC+4
//   DECODE   | read regs, ALUOut <= branch target, dispatch on op
//   MEMADR   | ALUOut <= rs1 + imm
//   MEMREAD  | read data memory at ALUOut
//   MEMWB    | rd <= loaded data
//   MEMWRITE | write rs2 to memory at ALUOut
//   EXECR    | ALUOut <= rs1 op rs2
//   EXECI    | ALUOut <= rs1 op imm
//   JAL      | PC <= target, ALUOut <= OldPC+4
//   ALUWB    | rd <= ALUOut
//   BEQ      | compare rs1/rs2, PC <= target when equal
module multicycle_controller
   import riscv_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       instr_done,
   output logic       illegal
);

   state_t  state, next_state, dec_state;
   alu_op_t alu_op;
   logic    pc_update, branch, ir_write, reg_write, mem_write, done, ill;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:  next_state = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = EXECR;
               OP_ITYPE:     next_state = EXECI;
               OP_JAL:       next_state = JAL;
               OP_BEQ:       next_state = BEQ;
               default:      next_state = FETCH;
            endcase
         end
         MEMADR:  next_state = op[5] ? MEMWRITE : MEMREAD;
         MEMREAD: next_state = MEMWB;
         EXECR:   next_state = ALUWB;
         EXECI:   next_state = ALUWB;
         JAL:     next_state = ALUWB;
         default: next_state = FETCH;
      endcase
   end

   // While reset is high the outputs decode as FETCH so the datapath sees a clean restart
   assign dec_state = reset ? FETCH : state;

   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      done      = 1'b0;
      ill       = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      alu_op    = ALUOP_ADD;
      case (dec_state)
         FETCH: begin
            ir_write  = 1'b1;
            pc_update = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            if (!(op inside {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ})) begin
               ill  = 1'b1;
               done = 1'b1;
            end
         end
         MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = RES_DATA;
            reg_write = 1'b1;
            done      = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            done      = 1'b1;
         end
         EXECR: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
         end
         EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         ALUWB: begin
            reg_write = 1'b1;
            done      = 1'b1;
         end
         BEQ: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
            done    = 1'b1;
         end
         default: ;
      endcase
   end

   assign PCWrite    = (pc_update | (branch & zero)) & ~reset;
   assign IRWrite    = ir_write  & ~reset;
   assign RegWrite   = reg_write & ~reset;
   assign MemWrite   = mem_write & ~reset;
   assign instr_done = done      & ~reset;
   assign illegal    = ill       & ~reset;

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = IMM_S;
         OP_BEQ:  ImmSrc = IMM_B;
         OP_JAL:  ImmSrc = IMM_J;
         default: ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: every output checked each cycle against hand-derived values.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic       instr_done, illegal;

   int checks   = 0;
   int failures = 0;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // packed order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl instr_done illegal
   function automatic logic [17:0] v(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] alc,
                                     input logic d, input logic il);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alc, d, il};
   endfunction

   task automatic chk(input string tag, input logic [17:0] exp);
      logic [17:0] obs;
      #1;
      obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUControl, instr_done, illegal};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b required=%b", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
   endtask

   task automatic chk_fetch(input string tag, input logic [1:0] imm);
      chk(tag, v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0,0));
   endtask

   task automatic chk_decode(input string tag, input logic [1:0] imm);
      chk(tag, v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0,0));
   endtask

   // R/I ALU instruction: FETCH, DECODE, EXEC, ALUWB
   task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [1:0] sb, input logic [2:0] alc);
      nxt(); set_instr(o, f3, f7, 1'b1);
      chk_fetch({tag, "_fetch"}, 2'b00);
      nxt(); chk_decode({tag, "_decode"}, 2'b00);
      nxt(); chk({tag, "_exec"}, v(0,0,0,0,0, 2'b00, 2'b10, sb, 2'b00, alc, 0,0));
      nxt(); chk({tag, "_aluwb"}, v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1,0));
   endtask

   initial begin
      reset = 1'b1;
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      nxt();
      chk("reset_hold", v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));

      // lw: FETCH DECODE MEMADR MEMREAD MEMWB (zero held high throughout)
      reset = 1'b0;
      chk_fetch("lw_fetch", 2'b00);
      nxt(); chk_decode("lw_decode", 2'b00);
      nxt(); chk("lw_memadr",  v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0,0));
      nxt(); chk("lw_memread", v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0));
      nxt(); chk("lw_memwb",   v(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1,0));

      // sw: FETCH DECODE MEMADR MEMWRITE
      nxt(); set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      chk_fetch("sw_fetch", 2'b01);
      nxt(); chk_decode("sw_decode", 2'b01);
      nxt(); chk("sw_memadr",   v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0,0));
      nxt(); chk("sw_memwrite", v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1,0));

      run_alu("r_sub",  7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
      run_alu("i_addi", 7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);
      run_alu("r_add",  7'b0110011, 3'b000, 1'b0, 2'b00, 3'b000);
      run_alu("r_slt",  7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101);
      run_alu("i_ori",  7'b0010011, 3'b110, 1'b0, 2'b01, 3'b011);
      run_alu("r_and",  7'b0110011, 3'b111, 1'b1, 2'b00, 3'b010);
      run_alu("i_sll",  7'b0010011, 3'b001, 1'b0, 2'b01, 3'b000);

      // beq taken then not taken; each returns to FETCH after 3 cycles
      nxt(); set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
      chk_fetch("beq_t_fetch", 2'b10);
      nxt(); chk_decode("beq_t_decode", 2'b10);
      nxt(); chk("beq_t_beq", v(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1,0));
      nxt(); set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
      chk_fetch("beq_n_fetch", 2'b10);
      nxt(); chk_decode("beq_n_decode", 2'b10);
      nxt(); chk("beq_n_beq", v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1,0));

      // jal
      nxt(); set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
      chk_fetch("jal_fetch", 2'b11);
      nxt(); chk_decode("jal_decode", 2'b11);
      nxt(); chk("jal_jal",   v(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0,0));
      nxt(); chk("jal_aluwb", v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1,0));

      // illegal opcode
      nxt(); set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
      chk_fetch("ill_fetch", 2'b00);
      nxt(); chk("ill_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1,1));

      // lw aborted by reset in MEMREAD
      nxt(); set_instr(7'b0000011, 3'b010, 1'b0, 1'b1);
      chk_fetch("abort_fetch", 2'b00);
      nxt(); chk_decode("abort_decode", 2'b00);
      nxt(); chk("abort_memadr", v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0,0));
      nxt(); reset = 1'b1;
      chk("abort_in_reset", v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));
      nxt(); reset = 1'b0;
      chk_fetch("abort_refetch", 2'b00);
      nxt(); chk_decode("abort_redecode", 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core, sharing one ALU and one unified instruction/data memory across cycles. A Moore FSM sequences fetch, decode, execute, memory and writeback, driving every mux select and write strobe of the datapath. An ALU decoder sub-block produces ALUControl. It supports lw, sw, R-type, I-type ALU, beq and jal. Any other opcode is flagged as illegal.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; state forced to FETCH on the clock edge
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  strobes and address select (AdrSrc: 0 = PC, 1 = Result)
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A (rs1)
- ALUSrcB  out  2  00 WriteData (rs2), 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  one-cycle pulse in DECODE when op is unsupported

## Operation
- Outputs are combinational from state (Moore); ImmSrc and ALUControl are also decoded from op/funct.
- Any select not listed for a state = 00/0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target).
  - lw 0000011 / sw 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - else illegal=1, instr_done=1 → FETCH
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 → MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 → FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, instr_done=1 → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1 → FETCH.
- PCWrite = PCUpdate | (Branch & zero).
- ALU decoder:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10: funct3 000 → sub if (funct7b5 & op[5]), else add.
  - ALUOp 10: funct3 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- ImmSrc by op: sw 01, beq 10, jal 11, all others 00.

## Timing
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Reset: on the first clock edge with reset=1, state=FETCH. While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0, and instr_done and illegal are 0. Other outputs take FETCH values.
- The first fetch happens on the first edge after reset falls.
- Reset asserted mid-instruction aborts it at the next edge. No partial strobes occur after that edge.
- There is no stall input; every state lasts exactly one cycle.
- Before the first reset edge, state is undefined. The bench holds reset ≥2 cycles.

## Structure
- Package riscv_mc_pkg holds:
  - state enum (FETCH…BEQ, 4 bits)
  - opcode constants
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/ALUControl encodings
  - ALUOp encoding
- Sub-module alu_decoder: (ALUOp, funct3, funct7b5, op5) → ALUControl, purely combinational.
- Top level holds the state register, next-state logic, output decode and PCWrite/reset gating.

## Test plan
- lw (op 0000011) after reset: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in cycle 5; instr_done pulses in cycle 5.
- sw (0100011): MemWrite=1 only in cycle 4, with AdrSrc=1 and ImmSrc=01. The full core program ends with a write of 25 to address 100.
- R-type sub (funct3 000, funct7b5=1, op[5]=1): ALUControl=001 in EXECR. Same funct3 with op 0010011 and funct7b5=1 gives addi: ALUControl=000.
- beq: zero=1 gives PCWrite=1 in cycle 3; zero=0 gives PCWrite=0. Either way the next state is FETCH after 3 cycles.
- jal: PCWrite=1 in cycle 3, RegWrite=1 with ResultSrc=00 in cycle 4, ImmSrc=11.
- Illegal op 0000000: illegal=1 in DECODE, then FETCH. Reset asserted in MEMREAD gives all strobes 0 and FETCH on the next edge.
